// File: rtl/cdc_tx_arbiter_if.sv
// Request/grant and crossing-channel signals of cdc_tx_arbiter.
// slave = arbiter side, master = requesters plus slow-domain side.
interface cdc_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         xfer_data;
  logic [SRC_W-1:0]              xfer_src;
  logic                          xfer_req;
  logic                          xfer_ack;
  logic                          xfer_done;
  logic                          busy;
  logic                          timeout;
  logic                          timeout_clr;

  modport slave (
    input  req, req_data, xfer_ack, timeout_clr,
    output grant, xfer_data, xfer_src, xfer_req, xfer_done, busy, timeout
  );

  modport master (
    output req, req_data, xfer_ack, timeout_clr,
    input  grant, xfer_data, xfer_src, xfer_req, xfer_done, busy, timeout
  );
endinterface

// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake fast-to-slow crossing
// channel between NUM_REQ fast-domain requesters.
module cdc_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             fast_clk,
  input logic             rst_n,
  cdc_tx_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SET  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic                   xreq_q, xreq_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   ack_s;
  logic                   quiet;
  logic                   any_req;
  logic                   found;
  logic [SRC_W-1:0]       cand;
  logic [SRC_W-1:0]       winner;
  logic [DATA_WIDTH-1:0]  payload [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign payload[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  assign quiet   = (ack_s == xreq_q);
  assign any_req = |bus.req;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (quiet && any_req) state_d = LOAD;
      LOAD:     state_d = WAIT_ACK;
      WAIT_ACK: if (quiet) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = '0;
    data_d    = data_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    xreq_d    = xreq_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (bus.timeout_clr) timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (quiet && any_req) begin
          grant_d[winner] = 1'b1;
          data_d          = payload[winner];
          src_d           = winner;
          ptr_d           = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
      end
      LOAD: begin
        xreq_d = ~xreq_q;
        cnt_d  = '0;
      end
      WAIT_ACK: begin
        // Flag fires once as the counter reaches its limit so a clear
        // issued while still waiting sticks; set overrides a same-cycle clear.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_SET) timeout_d = 1'b1;
        end
        if (quiet) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      src_q      <= '0;
      xreq_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.xfer_ack};
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      src_q      <= src_d;
      xreq_q     <= xreq_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.xfer_data = data_q;
  assign bus.xfer_src  = src_q;
  assign bus.xfer_req  = xreq_q;
  assign bus.xfer_done = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Scoreboard bench for cdc_tx_arbiter: expected grants are queued when requests
// are raised and popped by an independent monitor; a slow-domain model echoes xfer_req.
module tb_cdc_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 8;

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] data;
  } exp_t;

  logic fast_clk = 1'b0;
  logic slow_clk = 1'b0;
  logic rst_n;

  always #5 fast_clk = ~fast_clk;
  always #7 slow_clk = ~slow_clk;

  cdc_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  cdc_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .fast_clk(fast_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  int unsigned mdl_p;
  logic [DW-1:0] data_v [N];

  // Slow-domain model: synchronise xfer_req, echo it on xfer_ack after a delay.
  logic ack_model;
  logic s1, s2;
  int   dly_cnt;
  int   slow_delay;
  logic ack_hold;
  logic force_en, force_val;

  assign bus.xfer_ack = force_en ? force_val : ack_model;

  always @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; ack_model <= 1'b0; dly_cnt <= 0;
    end else begin
      s1 <= bus.xfer_req;
      s2 <= s1;
      if (s2 != ack_model && !ack_hold) begin
        if (dly_cnt >= slow_delay) begin
          ack_model <= s2;
          dly_cnt   <= 0;
        end else begin
          dly_cnt <= dly_cnt + 1;
        end
      end else begin
        dly_cnt <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant pops one expectation; toggle and done behaviour checked around it.
  initial begin
    logic          prev_grant, prev_xreq, prev_busy, exp_x;
    logic [DW-1:0] last_data;
    exp_t          e;
    prev_grant = 1'b0; prev_xreq = 1'b0; prev_busy = 1'b0; last_data = '0;
    forever begin
      @(negedge fast_clk);
      if (rst_n) begin
        if (prev_grant) begin
          exp_x = ~prev_xreq;
          chk("xfer_req toggle after grant", 32'(bus.xfer_req), 32'(exp_x));
        end
        if (|bus.grant) begin
          chk("grant only from idle", 32'(prev_busy), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected grant: got 0x%0h, expected none at %0t", bus.grant, $time);
          end else begin
            e = exp_q.pop_front();
            chk("grant one-hot", 32'(bus.grant), 32'(1) << e.idx);
            chk("xfer_data at grant", 32'(bus.xfer_data), 32'(e.data));
            chk("xfer_src at grant", 32'(bus.xfer_src), e.idx);
            last_data = e.data;
          end
        end
        if (bus.xfer_done) begin
          chk("busy low with done", 32'(bus.busy), 32'd0);
          chk("xfer_data held to done", 32'(bus.xfer_data), 32'(last_data));
        end
      end
      prev_grant = rst_n && (|bus.grant);
      prev_xreq  = bus.xfer_req;
      prev_busy  = bus.busy;
    end
  end

  // Reference: expected grant sequence from a pending set and the rotating pointer.
  task automatic start(input logic [N-1:0] mask, input logic [N-1:0] sticky,
                       input int unsigned n, output int unsigned pushed);
    logic [N-1:0] pending;
    int unsigned  w, c;
    bit           hit;
    exp_t         e;
    pending = mask;
    pushed  = 0;
    while (pushed < n && pending != '0) begin
      hit = 0;
      w   = 0;
      for (int unsigned j = 0; j < N; j++) begin
        c = (mdl_p + j) % N;
        if (!hit && pending[c]) begin hit = 1; w = c; end
      end
      e.idx  = w;
      e.data = data_v[w];
      exp_q.push_back(e);
      pushed++;
      mdl_p = (w + 1) % N;
      if (!sticky[w]) pending[w] = 1'b0;
    end
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_v[i];
    bus.req = bus.req | mask;
  endtask

  task automatic wait_grants(input int unsigned n, input logic [N-1:0] sticky);
    int unsigned got = 0;
    int cyc = 0;
    while (got < n && cyc < 2000) begin
      @(negedge fast_clk);
      cyc++;
      for (int i = 0; i < N; i++)
        if (bus.grant[i]) begin
          got++;
          if (!sticky[i]) bus.req[i] = 1'b0;
        end
    end
    chk("grants arrived in budget", got, n);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge fast_clk);
      cyc++;
    end while (bus.busy && cyc < 2000);
    chk("idle within budget", 32'(bus.busy), 32'd0);
  endtask

  task automatic clear_timeout();
    bus.timeout_clr = 1'b1;
    @(negedge fast_clk);
    bus.timeout_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned   pushed;
    logic [N-1:0]  mask, sticky;
    int unsigned   n, gcount;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.timeout_clr = 1'b0;
    force_en = 1'b0; force_val = 1'b0; ack_hold = 1'b0; slow_delay = 0;
    mdl_p = 0;
    for (int i = 0; i < N; i++) data_v[i] = '0;

    #2;
    chk("reset grant", 32'(bus.grant), 32'd0);
    chk("reset xfer_data", 32'(bus.xfer_data), 32'd0);
    chk("reset xfer_src", 32'(bus.xfer_src), 32'd0);
    chk("reset xfer_req", 32'(bus.xfer_req), 32'd0);
    chk("reset xfer_done", 32'(bus.xfer_done), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset timeout", 32'(bus.timeout), 32'd0);
    repeat (3) @(negedge fast_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge fast_clk);

    // Fairness with all requests held: 0,1,2,3,0.
    for (int i = 0; i < N; i++) data_v[i] = 8'h10 + 8'(i);
    start(4'b1111, 4'b1111, 5, pushed);
    wait_grants(pushed, 4'b1111);
    bus.req = '0;
    wait_idle();

    // Pointer wrap: grant 3, then 0101 gives 0 then 2.
    start(4'b1000, 4'b0000, 1, pushed);
    wait_grants(pushed, 4'b0000);
    wait_idle();
    start(4'b0101, 4'b0000, 2, pushed);
    wait_grants(pushed, 4'b0000);
    wait_idle();

    // Single request with a slower acknowledge; latency checked directly.
    slow_delay = 3;
    data_v[1] = 8'hA5;
    start(4'b0010, 4'b0000, 1, pushed);
    @(negedge fast_clk);
    chk("single grant latency", 32'(bus.grant), 32'h2);
    chk("single xfer_data", 32'(bus.xfer_data), 32'hA5);
    chk("single xfer_src", 32'(bus.xfer_src), 32'd1);
    bus.req = '0;
    @(negedge fast_clk);
    chk("single xfer_req raised", 32'(bus.xfer_req), 32'd1);
    wait_idle();

    // Randomised rounds, some with requests held past their grant.
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) data_v[i] = DW'($urandom);
      sticky = ($urandom_range(0, 3) == 0) ? (mask & N'($urandom)) : '0;
      n = $countones(mask) + ((sticky != '0) ? $urandom_range(0, 3) : 0);
      slow_delay = $urandom_range(0, 3);
      start(mask, sticky, n, pushed);
      wait_grants(pushed, sticky);
      bus.req = '0;
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge fast_clk);
    end

    // Timeout with acknowledge withheld; a second request waits behind it.
    slow_delay = 0;
    clear_timeout();
    chk("timeout cleared", 32'(bus.timeout), 32'd0);
    ack_hold = 1'b1;
    start(4'b0001, 4'b0000, 1, pushed);
    wait_grants(pushed, 4'b0000);
    gcount = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) begin
        data_v[1] = 8'h3C;
        start(4'b0010, 4'b0000, 1, pushed);
      end
      @(negedge fast_clk);
      if (|bus.grant) gcount++;
      if (k == 8) chk("timeout before limit", 32'(bus.timeout), 32'd0);
      if (k == 9) chk("timeout at limit", 32'(bus.timeout), 32'd1);
    end
    chk("no grant while waiting", gcount, 0);
    chk("busy while waiting", 32'(bus.busy), 32'd1);
    ack_hold = 1'b0;
    begin
      int cyc = 0;
      do begin
        @(negedge fast_clk);
        cyc++;
      end while (!bus.xfer_done && cyc < 2000);
      chk("late ack gives done", 32'(bus.xfer_done), 32'd1);
      chk("timeout sticky at done", 32'(bus.timeout), 32'd1);
    end
    wait_grants(1, 4'b0000);
    wait_idle();
    chk("timeout sticky after", 32'(bus.timeout), 32'd1);
    clear_timeout();
    chk("timeout_clr clears", 32'(bus.timeout), 32'd0);

    // Reset in the middle of WAIT_ACK, slow side reset with it.
    ack_hold = 1'b1;
    start(4'b0001, 4'b0000, 1, pushed);
    wait_grants(pushed, 4'b0000);
    repeat (3) @(negedge fast_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset grant", 32'(bus.grant), 32'd0);
    chk("async reset xfer_data", 32'(bus.xfer_data), 32'd0);
    chk("async reset xfer_src", 32'(bus.xfer_src), 32'd0);
    chk("async reset xfer_req", 32'(bus.xfer_req), 32'd0);
    chk("async reset xfer_done", 32'(bus.xfer_done), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    chk("async reset timeout", 32'(bus.timeout), 32'd0);
    chk("queue drained before reset", exp_q.size(), 0);
    mdl_p = 0;
    ack_hold = 1'b0;
    @(negedge fast_clk);
    rst_n = 1'b1;
    @(negedge fast_clk);
    data_v[0] = 8'h5A;
    start(4'b0001, 4'b0000, 1, pushed);
    @(negedge fast_clk);
    chk("post-reset grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    @(negedge fast_clk);
    chk("post-reset xfer_req", 32'(bus.xfer_req), 32'd1);
    wait_idle();

    // Out-of-step acknowledge after reset holds the arbiter in idle.
    force_en = 1'b1;
    force_val = 1'b1;
    rst_n = 1'b0;
    bus.req = '0;
    mdl_p = 0;
    repeat (2) @(negedge fast_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge fast_clk);
    data_v[0] = 8'hC3;
    start(4'b0001, 4'b0000, 1, pushed);
    gcount = 0;
    repeat (10) begin
      @(negedge fast_clk);
      if (|bus.grant) gcount++;
    end
    chk("no grant out of step", gcount, 0);
    chk("idle out of step", 32'(bus.busy), 32'd0);
    force_val = 1'b0;
    for (int k = 1; k <= SS + 1; k++) begin
      @(negedge fast_clk);
      chk("grant after ack settles", 32'(bus.grant), (k == SS + 1) ? 32'h1 : 32'h0);
    end
    bus.req = '0;
    force_en = 1'b0;
    wait_idle();

    repeat (4) @(negedge fast_clk);
    chk("all expected grants seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
